// File: rtl/front_spr_scan_if.sv
// Scanner-side bus: line start, attribute RAM port, object FIFO head and status.
// master = scanner, slave = the line-buffer/RAM side that talks to it.
interface front_spr_scan_if;
  logic       LSTART;
  logic [8:0] VLINE;
  logic [7:0] ATTR_ADDR;
  logic [7:0] ATTR_DATA;
  logic       OBJ_VALID;
  logic       OBJ_READY;
  logic [7:0] OBJ_CODE;
  logic [8:0] OBJ_X;
  logic [3:0] OBJ_ROW;
  logic [3:0] OBJ_COL;
  logic       SCAN_BUSY;
  logic       OVERFLOW;

  modport master (
    input  LSTART, VLINE, ATTR_DATA, OBJ_READY,
    output ATTR_ADDR, OBJ_VALID, OBJ_CODE, OBJ_X, OBJ_ROW, OBJ_COL,
           SCAN_BUSY, OVERFLOW
  );

  modport slave (
    output LSTART, VLINE, ATTR_DATA, OBJ_READY,
    input  ATTR_ADDR, OBJ_VALID, OBJ_CODE, OBJ_X, OBJ_ROW, OBJ_COL,
           SCAN_BUSY, OVERFLOW
  );
endinterface

// File: rtl/front_spr_scan.sv
// Per-line sprite scanner: walks the attribute RAM, keeps sprites whose 16-line
// window covers VLINE, and queues {code, X, row, colour} in a small output FIFO.
module front_spr_scan #(
  parameter int unsigned NSPR    = 64,
  parameter int unsigned FDEPTH  = 8,
  parameter int unsigned LINEMAX = 16
) (
  input logic              clk,
  input logic              RESETn,
  front_spr_scan_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, RD_ATTR, RD_Y, CMP, RD_CODE, RD_X, PUSH, NEXT
  } state_t;

  typedef struct packed {
    logic [7:0] code;
    logic [8:0] x;
    logic [3:0] row;
    logic [3:0] col;
  } obj_t;

  localparam int unsigned PW = $clog2(FDEPTH);
  localparam int unsigned CW = $clog2(LINEMAX + 1);

  typedef logic [PW:0]   fcnt_t;
  typedef logic [CW-1:0] cnt_t;

  localparam logic [5:0] LAST_IDX = 6'(NSPR - 1);
  localparam cnt_t       CNT_MAX  = cnt_t'(LINEMAX);
  localparam fcnt_t      FIFO_MAX = fcnt_t'(FDEPTH);

  state_t      state_q;
  logic [8:0]  vline_q;
  logic [5:0]  idx_q;
  cnt_t        cnt_q;
  logic [7:0]  addr_q;
  logic        busy_q;
  logic        ovf_q;
  logic        y8_q;
  logic        x8_q;
  logic [3:0]  col_q;
  logic [7:0]  code_q;
  logic [8:0]  x_q;
  logic [3:0]  row_q;

  obj_t        mem_q [FDEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  fcnt_t       fcnt_q;
  fcnt_t       fcnt_d;

  logic [8:0]  diff;
  logic        hit;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  obj_t        head;

  // Modular 9-bit distance lets sprites straddle the top/bottom line wrap.
  assign diff = vline_q - {y8_q, bus.ATTR_DATA};
  assign hit  = (diff[8:4] == 5'd0);

  always_comb begin
    fifo_full  = (fcnt_q == FIFO_MAX);
    fifo_empty = (fcnt_q == '0);
    pop        = ~fifo_empty & bus.OBJ_READY & ~bus.LSTART;
    push       = (state_q == PUSH) & (~fifo_full | pop) & ~bus.LSTART;
    fcnt_d     = fcnt_q;
    if (push && !pop) fcnt_d = fcnt_q + 1'b1;
    if (pop && !push) fcnt_d = fcnt_q - 1'b1;
  end

  // ATTR_ADDR is loaded on entry to each read state so the synchronous RAM
  // returns that byte during the following state, where it is captured.
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      vline_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      y8_q    <= 1'b0;
      x8_q    <= 1'b0;
      col_q   <= '0;
      code_q  <= '0;
      x_q     <= '0;
      row_q   <= '0;
    end else if (bus.LSTART) begin
      vline_q <= bus.VLINE;
      idx_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b1;
      addr_q  <= {6'd0, 2'd3};
      state_q <= RD_ATTR;
    end else begin
      unique case (state_q)
        IDLE: ;
        RD_ATTR: begin
          addr_q  <= {idx_q, 2'd0};
          state_q <= RD_Y;
        end
        RD_Y: begin
          y8_q    <= bus.ATTR_DATA[7];
          x8_q    <= bus.ATTR_DATA[6];
          col_q   <= bus.ATTR_DATA[3:0];
          addr_q  <= {idx_q, 2'd1};
          state_q <= CMP;
        end
        CMP: begin
          row_q <= diff[3:0];
          if (hit) begin
            addr_q  <= {idx_q, 2'd2};
            state_q <= RD_CODE;
          end else begin
            state_q <= NEXT;
          end
        end
        RD_CODE: begin
          code_q  <= bus.ATTR_DATA;
          state_q <= RD_X;
        end
        RD_X: begin
          x_q     <= {x8_q, bus.ATTR_DATA};
          state_q <= PUSH;
        end
        PUSH: begin
          if (push) begin
            cnt_q   <= cnt_q + 1'b1;
            state_q <= NEXT;
          end
        end
        NEXT: begin
          if (idx_q == LAST_IDX) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q == CNT_MAX) begin
            ovf_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            idx_q   <= idx_q + 6'd1;
            addr_q  <= {idx_q + 6'd1, 2'd3};
            state_q <= RD_ATTR;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // When full, a same-cycle pop frees the head slot that wr_q points at.
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      rd_q   <= '0;
      wr_q   <= '0;
      fcnt_q <= '0;
      for (int unsigned i = 0; i < FDEPTH; i++) mem_q[i] <= '0;
    end else if (bus.LSTART) begin
      rd_q   <= '0;
      wr_q   <= '0;
      fcnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= '{code: code_q, x: x_q, row: row_q, col: col_q};
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      fcnt_q <= fcnt_d;
    end
  end

  assign head          = mem_q[rd_q];
  assign bus.OBJ_VALID = ~fifo_empty;
  assign bus.OBJ_CODE  = head.code;
  assign bus.OBJ_X     = head.x;
  assign bus.OBJ_ROW   = head.row;
  assign bus.OBJ_COL   = head.col;
  assign bus.ATTR_ADDR = addr_q;
  assign bus.SCAN_BUSY = busy_q;
  assign bus.OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_front_spr_scan.sv
// Bench for front_spr_scan: synchronous attribute RAM model plus a scoreboard
// of expected FIFO entries checked at every accepted handshake.
module tb_front_spr_scan;
  localparam int unsigned NSPR    = 64;
  localparam int unsigned FDEPTH  = 8;
  localparam int unsigned LINEMAX = 16;

  typedef logic [24:0] obj_t;

  logic clk = 1'b0;
  logic RESETn;

  front_spr_scan_if bus ();

  front_spr_scan #(.NSPR(NSPR), .FDEPTH(FDEPTH), .LINEMAX(LINEMAX)) dut (
    .clk    (clk),
    .RESETn (RESETn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [256];
  always @(posedge clk) bus.ATTR_DATA <= ram[bus.ATTR_ADDR];

  obj_t exp_q [$];
  obj_t exp_h;
  int   checks = 0;
  int   errors = 0;
  int   rx_cnt = 0;
  bit   saw_valid = 1'b0;
  obj_t got;

  assign got = {bus.OBJ_CODE, bus.OBJ_X, bus.OBJ_ROW, bus.OBJ_COL};

  always @(negedge clk) begin
    if (RESETn && bus.OBJ_VALID) saw_valid = 1'b1;
    if (RESETn && bus.OBJ_VALID && bus.OBJ_READY && !bus.LSTART) begin
      checks++;
      rx_cnt++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL obj_unexpected got=%h expected=none", got);
      end else begin
        exp_h = exp_q.pop_front();
        if (got !== exp_h) begin
          errors++;
          $display("FAIL obj_entry got=%h expected=%h", got, exp_h);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ent(input int i, input logic [8:0] y, input logic [7:0] code,
                         input logic [8:0] x, input logic [3:0] col);
    ram[4*i]   = y[7:0];
    ram[4*i+1] = code;
    ram[4*i+2] = x[7:0];
    ram[4*i+3] = {y[8], x[8], 2'b00, col};
  endtask

  // Y = 0x100 never falls within 16 lines of any VLINE below 0x100.
  task automatic clear_ram();
    for (int i = 0; i < int'(NSPR); i++) set_ent(i, 9'h100, 8'h00, 9'h000, 4'h0);
  endtask

  task automatic model_scan(input logic [8:0] vl, output bit ovf);
    int n;
    logic [8:0] y;
    logic [8:0] d;
    n   = 0;
    ovf = 1'b0;
    for (int i = 0; i < int'(NSPR); i++) begin
      y = {ram[4*i+3][7], ram[4*i]};
      d = vl - y;
      if (d[8:4] == 5'd0) begin
        exp_q.push_back({ram[4*i+1], ram[4*i+3][6], ram[4*i+2], d[3:0], ram[4*i+3][3:0]});
        n++;
        if (n == int'(LINEMAX)) begin
          ovf = (i != int'(NSPR) - 1);
          break;
        end
      end
    end
  endtask

  task automatic start_scan(input logic [8:0] vl);
    bus.VLINE  = vl;
    bus.LSTART = 1'b1;
    tick();
    bus.LSTART = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (!bus.SCAN_BUSY) break;
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s busy_timeout got=%0d cycles limit=%0d", nm, n, budget);
    end
  endtask

  task automatic drain();
    repeat (FDEPTH + 4) tick();
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    repeat (2) tick();
    checks++; if (bus.OBJ_VALID !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b expected=0", bus.OBJ_VALID); end
    checks++; if (bus.SCAN_BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b expected=0", bus.SCAN_BUSY); end
    checks++; if (bus.OVERFLOW !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b expected=0", bus.OVERFLOW); end
    checks++; if (bus.ATTR_ADDR !== 8'h00) begin errors++; $display("FAIL rst_addr got=%h expected=00", bus.ATTR_ADDR); end
    checks++; if (got !== 25'h0) begin errors++; $display("FAIL rst_head got=%h expected=0", got); end
    RESETn = 1'b1;
    tick();
  endtask

  task automatic test_all_miss();
    int n;
    clear_ram();
    saw_valid     = 1'b0;
    bus.OBJ_READY = 1'b1;
    start_scan(9'h010);
    wait_idle("all_miss", 2000, n);
    tick();
    checks++; if (n !== int'(4*NSPR)) begin errors++; $display("FAIL miss_busy_cycles got=%0d expected=%0d", n, 4*NSPR); end
    checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL miss_valid got=%b expected=0", saw_valid); end
    checks++; if (bus.OVERFLOW !== 1'b0) begin errors++; $display("FAIL miss_ovf got=%b expected=0", bus.OVERFLOW); end
  endtask

  task automatic test_single_hit();
    int n;
    clear_ram();
    set_ent(5, 9'h020, 8'h3A, 9'h1F0, 4'h7);
    exp_q.push_back({8'h3A, 9'h1F0, 4'hB, 4'h7});
    rx_cnt        = 0;
    bus.OBJ_READY = 1'b1;
    start_scan(9'h02B);
    wait_idle("single", 2000, n);
    drain();
    checks++; if (rx_cnt !== 1) begin errors++; $display("FAIL single_count got=%0d expected=1", rx_cnt); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL single_left got=%0d expected=0", exp_q.size()); end
    checks++; if (bus.OVERFLOW !== 1'b0) begin errors++; $display("FAIL single_ovf got=%b expected=0", bus.OVERFLOW); end
  endtask

  task automatic test_overflow();
    int n;
    bit ovf_e;
    clear_ram();
    for (int k = 0; k < 20; k++)
      set_ent(k, 9'(80 - k % 16), 8'(k + 16), 9'(k * 25), 4'(k));
    model_scan(9'h050, ovf_e);
    rx_cnt        = 0;
    bus.OBJ_READY = 1'b1;
    start_scan(9'h050);
    wait_idle("overflow", 2000, n);
    drain();
    checks++; if (rx_cnt !== int'(LINEMAX)) begin errors++; $display("FAIL ovf_count got=%0d expected=%0d", rx_cnt, LINEMAX); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL ovf_left got=%0d expected=0", exp_q.size()); end
    checks++; if (bus.OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b expected=1", bus.OVERFLOW); end
  endtask

  task automatic test_ywrap();
    int n;
    clear_ram();
    set_ent(0, 9'h1F8, 8'h55, 9'h012, 4'h9);
    exp_q.push_back({8'h55, 9'h012, 4'hC, 4'h9});
    rx_cnt        = 0;
    bus.OBJ_READY = 1'b1;
    start_scan(9'h004);
    wait_idle("wrap_hit", 2000, n);
    drain();
    checks++; if (rx_cnt !== 1) begin errors++; $display("FAIL wrap_hit_count got=%0d expected=1", rx_cnt); end
    checks++; if (bus.OVERFLOW !== 1'b0) begin errors++; $display("FAIL wrap_ovf_clear got=%b expected=0", bus.OVERFLOW); end
    rx_cnt = 0;
    start_scan(9'h008);
    wait_idle("wrap_miss", 2000, n);
    drain();
    checks++; if (rx_cnt !== 0) begin errors++; $display("FAIL wrap_miss_count got=%0d expected=0", rx_cnt); end
  endtask

  task automatic test_stall();
    int   n;
    bit   ovf_e;
    bit   stable;
    obj_t first_e;
    obj_t head;
    clear_ram();
    for (int k = 0; k < 10; k++)
      set_ent(k, 9'(128 - k), 8'(160 + k), 9'(256 + k * 7), 4'(k));
    model_scan(9'h080, ovf_e);
    first_e       = exp_q[0];
    rx_cnt        = 0;
    bus.OBJ_READY = 1'b0;
    start_scan(9'h080);
    n = 0;
    while (n < 50 && !bus.OBJ_VALID) begin
      @(negedge clk);
      n++;
    end
    checks++; if (bus.OBJ_VALID !== 1'b1) begin errors++; $display("FAIL stall_first_valid got=%b expected=1", bus.OBJ_VALID); end
    head   = got;
    stable = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (got !== head || bus.OBJ_VALID !== 1'b1) stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL stall_head_stable got=%b expected=1", stable); end
    checks++; if (head !== first_e) begin errors++; $display("FAIL stall_head got=%h expected=%h", head, first_e); end
    checks++; if (bus.SCAN_BUSY !== 1'b1) begin errors++; $display("FAIL stall_busy got=%b expected=1", bus.SCAN_BUSY); end
    checks++; if (bus.ATTR_ADDR !== 8'h22) begin errors++; $display("FAIL stall_addr got=%h expected=22", bus.ATTR_ADDR); end
    @(posedge clk);
    #1;
    bus.OBJ_READY = 1'b1;
    wait_idle("stall", 2000, n);
    drain();
    checks++; if (rx_cnt !== 10) begin errors++; $display("FAIL stall_count got=%0d expected=10", rx_cnt); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL stall_left got=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_abort();
    int n;
    bit ovf_e;
    clear_ram();
    for (int k = 0; k < 20; k++)
      set_ent(k, 9'(192 - k % 16), 8'(k + 48), 9'(300 + k), 4'(15 - k % 16));
    bus.OBJ_READY = 1'b0;
    start_scan(9'h0C0);
    repeat (48) tick();
    checks++; if (bus.OBJ_VALID !== 1'b1) begin errors++; $display("FAIL abort_pre_valid got=%b expected=1", bus.OBJ_VALID); end
    exp_q.delete();
    model_scan(9'h0C5, ovf_e);
    rx_cnt        = 0;
    bus.OBJ_READY = 1'b1;
    start_scan(9'h0C5);
    @(negedge clk);
    checks++; if (bus.OBJ_VALID !== 1'b0) begin errors++; $display("FAIL abort_flush got=%b expected=0", bus.OBJ_VALID); end
    checks++; if (bus.ATTR_ADDR !== 8'h03) begin errors++; $display("FAIL abort_addr got=%h expected=03", bus.ATTR_ADDR); end
    checks++; if (bus.SCAN_BUSY !== 1'b1) begin errors++; $display("FAIL abort_busy got=%b expected=1", bus.SCAN_BUSY); end
    wait_idle("abort", 2000, n);
    drain();
    checks++; if (rx_cnt !== 15) begin errors++; $display("FAIL abort_count got=%0d expected=15", rx_cnt); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL abort_left got=%0d expected=0", exp_q.size()); end
    checks++; if (bus.OVERFLOW !== ovf_e) begin errors++; $display("FAIL abort_ovf got=%b expected=%b", bus.OVERFLOW, ovf_e); end
  endtask

  task automatic test_reset_mid_scan();
    bit ovf_e;
    exp_q.delete();
    model_scan(9'h0C0, ovf_e);
    bus.OBJ_READY = 1'b0;
    start_scan(9'h0C0);
    repeat (30) tick();
    RESETn = 1'b0;
    #1;
    exp_q.delete();
    checks++; if (bus.OBJ_VALID !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b expected=0", bus.OBJ_VALID); end
    checks++; if (bus.SCAN_BUSY !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b expected=0", bus.SCAN_BUSY); end
    checks++; if (bus.ATTR_ADDR !== 8'h00) begin errors++; $display("FAIL rstmid_addr got=%h expected=00", bus.ATTR_ADDR); end
    checks++; if (got !== 25'h0) begin errors++; $display("FAIL rstmid_head got=%h expected=0", got); end
    tick();
    RESETn        = 1'b1;
    saw_valid     = 1'b0;
    bus.OBJ_READY = 1'b1;
    repeat (300) tick();
    checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL rstmid_emit got=%b expected=0", saw_valid); end
    checks++; if (bus.SCAN_BUSY !== 1'b0) begin errors++; $display("FAIL rstmid_idle got=%b expected=0", bus.SCAN_BUSY); end
  endtask

  initial begin
    bus.LSTART    = 1'b0;
    bus.VLINE     = '0;
    bus.OBJ_READY = 1'b0;
    RESETn        = 1'b0;
    clear_ram();
    test_reset();
    test_all_miss();
    test_single_hit();
    test_overflow();
    test_ywrap();
    test_stall();
    test_abort();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
